alu_result_serializer: RTL and testbench
========================================

// Module: alu_result_serializer
// PURPOSE
//   Consumer end of the arithmetic unit's result interface. Captures each new result
//   (result word + carry, qualified by the unit's valid flag) and streams it as bytes,
//   LSB first, over a valid/ready byte channel toward the UART TX path.
//   Provides a 1-entry holding buffer so that results arriving mid-frame are not lost.
// PARAMETERS
//   OUT_WIDTH   16  result width in bits; must be a multiple of 8 and at least 8
//   SEND_CARRY  1   1: append carry byte {7'b0,carry}; 0: result bytes only
// PORTS
//   clk         in   1          system clock; single clock domain
//   rst         in   1          synchronous, active-high reset
//   res_in      in   OUT_WIDTH  result word from arithmetic unit
//   carry_in    in   1          carry from arithmetic unit
//   res_valid   in   1          result valid flag; level signal, may stay high many cycles
//   tx_data     out  8          byte to transmitter
//   tx_valid    out  1          tx_data valid
//   tx_ready    in   1          transmitter accepts byte when tx_valid & tx_ready
//   busy        out  1          frame in progress or pending entry held
//   frame_done  out  1          1-cycle pulse on transfer of a frame's last byte
//   drop_pulse  out  1          1-cycle pulse when a new result is discarded
//   drop_count  out  8          count of discarded results; saturates at 8'hFF
// BEHAVIOUR
//   - Reset (rst=1 at posedge): all outputs 0, FSM=IDLE, byte index 0, pending empty,
//     edge register prev_valid=0. A res_valid held high through reset counts as a new edge.
//   - New result = res_valid & ~prev_valid (rising edge); res_in/carry_in sampled that cycle.
//     A high level yields exactly one capture.
//   - NBYTES = OUT_WIDTH/8 + SEND_CARRY. Byte k = res[8k+7:8k]; final byte (if SEND_CARRY)
//     = {7'b0,carry}.
//   - Transfer = tx_valid & tx_ready at posedge. While tx_valid=1 and no transfer occurs,
//     tx_data is held stable. tx_valid does not depend combinationally on tx_ready.
//   - FSM IDLE: tx_valid=0. A new result loads the active register, idx=0 -> SEND.
//     Latency: edge sampled at cycle N -> tx_valid=1 with byte0 at cycle N+1.
//   - FSM SEND: tx_valid=1, tx_data=byte[idx]. A transfer with idx<NBYTES-1 -> idx+1.
//     A transfer with idx=NBYTES-1 -> frame_done=1 next cycle, plus:
//       * pending full: promote pending to active, idx=0, remain SEND (no idle bubble).
//       * pending empty, new edge this cycle: load it directly to active, remain SEND.
//       * otherwise -> IDLE.
//   - New edge while in SEND, other than the direct-load case above:
//     pending empty -> store in pending. Pending full and no promotion this cycle ->
//     discard the new result, drop_pulse=1, drop_count+1 (saturating).
//     Promotion and new edge in the same cycle -> new result fills the freed pending slot
//     (no drop).
//   - busy = (state!=IDLE) | pending_full.
//   - rst asserted mid-frame: frame aborted, tx_valid=0 next cycle, pending cleared,
//     drop_count cleared. A partial frame is never resumed.
// STRUCTURE
//   - Package alu_ser_pkg: state enum {IDLE,SEND}; localparam function nbytes(OUT_WIDTH,
//     SEND_CARRY); byte-index width constant.
//   - Sub-module alu_res_holdbuf: 1-entry holding buffer {res,carry} with load/pop/full.
//   - Top level holds the edge detector, active shift/index register, FSM and drop counter.
// TESTING
//   1. res_in=16'hBEEF, carry=1, 1-cycle valid edge at N, tx_ready=1 -> tx_data EF,BE,01
//      at N+1..N+3; frame_done at N+4; busy=0 at N+4.
//   2. Same as 1 with tx_ready low for 3 cycles at byte1 -> BE held stable on tx_data
//      with tx_valid=1; no byte repeated or skipped.
//   3. res_valid held high for 6 cycles with changing res_in -> exactly one frame carrying
//      the first-cycle value; drop_count=0.
//   4. tx_ready=0; edges for 16'h1111, 16'h2222, 16'h3333 -> 3333 dropped (drop_pulse,
//      drop_count=1); then tx_ready=1 -> frames 11,11,00 then 22,22,00, back to back.
//   5. Edge arrives on the same cycle as the last byte transfer, pending empty -> the
//      next cycle starts the new frame with byte0; frame_done=1; no drop.
//   6. rst=1 after byte0 of 16'hA55A -> tx_valid=0 and busy=0 next cycle; next edge after
//      rst releases sends a full fresh frame. SEND_CARRY=0 build: 2 bytes per frame.

Source files
------------

// File: rtl/alu_ser_pkg.sv
// rtl/alu_ser_pkg.sv - shared types and constants for the ALU result serializer
//
// Purpose: serializer FSM state type, frame length helper and byte-index width.
// Ports: none (package).

package alu_ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  // Byte index register width; comfortably covers any practical frame length.
  localparam int unsigned IDX_W = 8;

  // Bytes per frame: result bytes plus an optional trailing carry byte.
  function automatic int unsigned nbytes(input int unsigned out_width,
                                         input int unsigned send_carry);
    return (out_width / 8) + ((send_carry != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/alu_res_holdbuf.sv
// rtl/alu_res_holdbuf.sv - one-entry holding buffer for a formatted result frame
//
// Purpose: holds one frame that arrived while another frame is being sent.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   load_i     write data_i into the slot (wins over pop_i; slot stays full)
//   pop_i      release the slot
//   data_i     frame to store
//   data_o     stored frame
//   full_o     slot occupied

module alu_res_holdbuf #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o
);

  logic [W-1:0] data_q;
  logic         full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (load_i) begin
        data_q <= data_i;
        full_q <= 1'b1;
      end else if (pop_i) begin
        full_q <= 1'b0;
      end
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/alu_result_serializer.sv
// rtl/alu_result_serializer.sv - streams ALU results as LSB-first bytes over valid/ready
//
// Purpose: captures each rising edge of res_valid, formats the result (plus optional
// carry byte) into a frame and sends it byte by byte; one further result may wait in
// a holding buffer, later ones are dropped and counted.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   res_in        result word; carry_in carry bit; res_valid level-valid flag
//   tx_data       byte out; tx_valid byte valid; tx_ready downstream accept
//   busy          frame in progress or entry pending
//   frame_done    pulse after the last byte of a frame is transferred
//   drop_pulse    pulse when a result is discarded; drop_count saturating drop tally

module alu_result_serializer
  import alu_ser_pkg::*;
#(
  parameter int unsigned OUT_WIDTH  = 16,
  parameter bit          SEND_CARRY = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OUT_WIDTH-1:0] res_in,
  input  logic                 carry_in,
  input  logic                 res_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 drop_pulse,
  output logic [7:0]           drop_count
);

  localparam int unsigned     NBYTES   = nbytes(OUT_WIDTH, 32'(SEND_CARRY));
  localparam int unsigned     FW       = NBYTES * 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  ser_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FW-1:0]    act_q, act_d;
  logic             prev_valid_q;
  logic             done_q, done_d;
  logic             drop_q, drop_d;
  logic [7:0]       dcnt_q, dcnt_d;

  logic [FW-1:0]    new_frame;
  logic [FW-1:0]    hb_data;
  logic             hb_full;
  logic             hb_load;
  logic             hb_pop;
  logic             new_res;
  logic             xfer;
  logic             last_byte;

  // Frame is formatted at capture time so the active register is a plain
  // right-shift register: the byte on the wire is always its low byte.
  generate
    if (SEND_CARRY) begin : g_carry
      assign new_frame = {7'b0, carry_in, res_in};
    end else begin : g_nocarry
      logic unused_carry;
      assign unused_carry = carry_in;
      assign new_frame    = res_in;
    end
  endgenerate

  assign new_res   = res_valid & ~prev_valid_q;
  assign tx_valid  = (state_q == SEND);
  assign xfer      = tx_valid & tx_ready;
  assign last_byte = (idx_q == LAST_IDX);

  alu_res_holdbuf #(
    .W (FW)
  ) u_holdbuf (
    .clk    (clk),
    .rst    (rst),
    .load_i (hb_load),
    .pop_i  (hb_pop),
    .data_i (new_frame),
    .data_o (hb_data),
    .full_o (hb_full)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    act_d   = act_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    dcnt_d  = dcnt_q;
    hb_load = 1'b0;
    hb_pop  = 1'b0;

    case (state_q)
      IDLE: begin
        if (new_res) begin
          act_d   = new_frame;
          idx_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        if (xfer) begin
          if (!last_byte) begin
            idx_d = idx_q + 1'b1;
            act_d = act_q >> 8;
          end else begin
            done_d = 1'b1;
            idx_d  = '0;
            if (hb_full) begin
              // Promote the waiting frame; a simultaneous new result
              // takes over the slot being freed.
              act_d   = hb_data;
              hb_pop  = 1'b1;
              hb_load = new_res;
            end else if (new_res) begin
              act_d = new_frame;
            end else begin
              act_d   = '0;
              state_d = IDLE;
            end
          end
        end

        // Results not already absorbed by the end-of-frame handling above.
        if (new_res && !(xfer && last_byte)) begin
          if (!hb_full) begin
            hb_load = 1'b1;
          end else begin
            drop_d = 1'b1;
            if (dcnt_q != 8'hFF) begin
              dcnt_d = dcnt_q + 8'd1;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      act_q        <= '0;
      prev_valid_q <= 1'b0;
      done_q       <= 1'b0;
      drop_q       <= 1'b0;
      dcnt_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      act_q        <= act_d;
      prev_valid_q <= res_valid;
      done_q       <= done_d;
      drop_q       <= drop_d;
      dcnt_q       <= dcnt_d;
    end
  end

  assign tx_data    = tx_valid ? act_q[7:0] : 8'h00;
  assign busy       = tx_valid | hb_full;
  assign frame_done = done_q;
  assign drop_pulse = drop_q;
  assign drop_count = dcnt_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// tb/tb_alu_result_serializer.sv - self-checking bench for alu_result_serializer

module tb_alu_result_serializer;

  localparam int NB = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] res_in;
  logic        carry_in;
  logic        res_valid;
  logic        tx_ready;
  logic [7:0]  tx_data, tx_data0;
  logic        tx_valid, tx_valid0;
  logic        busy, busy0;
  logic        frame_done, frame_done0;
  logic        drop_pulse, drop_pulse0;
  logic [7:0]  drop_count, drop_count0;

  alu_result_serializer #(.OUT_WIDTH(16), .SEND_CARRY(1'b1)) dut (
    .clk(clk), .rst(rst), .res_in(res_in), .carry_in(carry_in), .res_valid(res_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .frame_done(frame_done), .drop_pulse(drop_pulse), .drop_count(drop_count)
  );

  alu_result_serializer #(.OUT_WIDTH(16), .SEND_CARRY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .res_in(res_in), .carry_in(carry_in), .res_valid(res_valid),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready), .busy(busy0),
    .frame_done(frame_done0), .drop_pulse(drop_pulse0), .drop_count(drop_count0)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observed transfers and the reference model's predicted transfers.
  logic [7:0] got_q[$];
  logic [7:0] got0_q[$];
  logic [7:0] exp_q[$];

  // Reference model: bytes still owed by the DUT (active frame then pending frame).
  logic [7:0] m_q[$];
  bit         m_prev;
  int         m_dc;
  bit         m_fd_next;
  bit         m_dp_next;
  int         vmis, fdmis, dpmis, dcmis;

  // One clock: apply inputs, record what the DUT shows against the model, then
  // advance the model by the rules of the block and step past the edge.
  task automatic tick(input bit v, input logic [15:0] d, input bit c, input bit r);
    int sz, fcnt, rem;
    bit nr, xf, lastx;
    res_valid = v;
    res_in    = d;
    carry_in  = c;
    tx_ready  = r;
    #1;
    if (tx_valid !== (m_q.size() > 0)) vmis++;
    if (busy !== (m_q.size() > 0)) vmis++;
    if (frame_done !== m_fd_next) fdmis++;
    if (drop_pulse !== m_dp_next) dpmis++;
    if (drop_count !== 8'(m_dc)) dcmis++;
    if (tx_valid && r) got_q.push_back(tx_data);
    if (tx_valid0 && r) got0_q.push_back(tx_data0);
    m_fd_next = 1'b0;
    m_dp_next = 1'b0;
    if (rst) begin
      m_q.delete();
      m_prev = 1'b0;
      m_dc   = 0;
    end else begin
      nr     = v && !m_prev;
      m_prev = v;
      sz     = m_q.size();
      fcnt   = (sz + NB - 1) / NB;
      rem    = (sz == 0) ? 0 : ((sz - 1) % NB) + 1;
      xf     = (sz > 0) && r;
      lastx  = xf && (rem == 1);
      if (xf) exp_q.push_back(m_q.pop_front());
      m_fd_next = lastx;
      if (nr) begin
        if (fcnt < 2 || lastx) begin
          m_q.push_back(d[7:0]);
          m_q.push_back(d[15:8]);
          m_q.push_back({7'b0, c});
        end else begin
          m_dp_next = 1'b1;
          if (m_dc < 255) m_dc++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_streams();
    got_q.delete();
    got0_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; res_valid = 1'b0; res_in = '0; carry_in = 1'b0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (frame_done !== 1'b0 || drop_pulse !== 1'b0) begin
      bad++; $display("FAIL reset_pulses got=%b%b want=00", frame_done, drop_pulse); end
    total++; if (drop_count !== 8'h00) begin bad++; $display("FAIL reset_drop_count got=%h want=00", drop_count); end
    m_q.delete(); m_prev = 1'b0; m_dc = 0; m_fd_next = 1'b0; m_dp_next = 1'b0;
    vmis = 0; fdmis = 0; dpmis = 0; dcmis = 0;
    rst = 1'b0;
    clear_streams();
  endtask

  task automatic test_single_frame();
    logic [7:0] e[3];
    e[0] = 8'hEF; e[1] = 8'hBE; e[2] = 8'h01;
    tick(1, 16'hBEEF, 1, 1);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (tx_valid !== 1'b1 || tx_data !== e[k]) begin
        bad++; $display("FAIL single_byte%0d got=%b/%h want=1/%h", k, tx_valid, tx_data, e[k]);
      end
      tick(0, 16'h0000, 0, 1);
    end
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL single_frame_done got=%b want=1", frame_done); end
    total++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      bad++; $display("FAIL single_idle got=%b/%b want=0/0", busy, tx_valid); end
    tick(0, 16'h0000, 0, 1);
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL single_done_pulse got=%b want=0", frame_done); end
    clear_streams();
  endtask

  task automatic test_backpressure();
    tick(1, 16'hBEEF, 1, 1);
    tick(0, 16'h0000, 0, 1);
    for (int k = 0; k < 3; k++) begin
      tick(0, 16'h0000, 0, 0);
      total++;
      if (tx_valid !== 1'b1 || tx_data !== 8'hBE) begin
        bad++; $display("FAIL hold_stable%0d got=%b/%h want=1/be", k, tx_valid, tx_data);
      end
    end
    repeat (3) tick(0, 16'h0000, 0, 1);
    total++;
    if (got_q.size() != 3 || got_q[0] !== 8'hEF || got_q[1] !== 8'hBE || got_q[2] !== 8'h01) begin
      bad++; $display("FAIL hold_stream got=%p want=ef be 01", got_q);
    end
    clear_streams();
  endtask

  task automatic test_level_valid();
    for (int k = 0; k < 6; k++) tick(1, 16'hC0DE + 16'(k * 16'h0111), 1'(k), 1);
    repeat (3) tick(0, 16'h0000, 0, 1);
    total++;
    if (got_q.size() != 3 || got_q[0] !== 8'hDE || got_q[1] !== 8'hC0 || got_q[2] !== 8'h00) begin
      bad++; $display("FAIL level_one_frame got=%p want=de c0 00", got_q);
    end
    total++; if (drop_count !== 8'h00) begin bad++; $display("FAIL level_drop_count got=%h want=00", drop_count); end
    clear_streams();
  endtask

  task automatic test_drop_and_back_to_back();
    logic [7:0] e[6];
    e[0] = 8'h11; e[1] = 8'h11; e[2] = 8'h00; e[3] = 8'h22; e[4] = 8'h22; e[5] = 8'h00;
    tick(1, 16'h1111, 0, 0); tick(0, 16'h0000, 0, 0);
    tick(1, 16'h2222, 0, 0); tick(0, 16'h0000, 0, 0);
    tick(1, 16'h3333, 0, 0);
    total++; if (drop_pulse !== 1'b1) begin bad++; $display("FAIL drop_pulse got=%b want=1", drop_pulse); end
    total++; if (drop_count !== 8'h01) begin bad++; $display("FAIL drop_count got=%h want=01", drop_count); end
    tick(0, 16'h0000, 0, 0);
    total++; if (drop_pulse !== 1'b0) begin bad++; $display("FAIL drop_pulse_width got=%b want=0", drop_pulse); end
    repeat (6) tick(0, 16'h0000, 0, 1);
    total++; if (got_q.size() != 6) begin bad++; $display("FAIL b2b_count got=%0d want=6", got_q.size()); end
    for (int k = 0; k < 6 && k < got_q.size(); k++) begin
      total++;
      if (got_q[k] !== e[k]) begin bad++; $display("FAIL b2b_byte%0d got=%h want=%h", k, got_q[k], e[k]); end
    end
    total++; if (busy !== 1'b0 || frame_done !== 1'b1) begin
      bad++; $display("FAIL b2b_end got=%b/%b want=0/1", busy, frame_done); end
    tick(0, 16'h0000, 0, 1);
    clear_streams();
  endtask

  task automatic test_edge_on_last_byte();
    tick(1, 16'h1357, 0, 1);
    tick(0, 16'h0000, 0, 1);
    tick(0, 16'h0000, 0, 1);
    tick(1, 16'h2468, 1, 1);
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h68) begin
      bad++; $display("FAIL direct_load got=%b/%h want=1/68", tx_valid, tx_data);
    end
    total++; if (frame_done !== 1'b1 || drop_pulse !== 1'b0) begin
      bad++; $display("FAIL direct_load_pulses got=%b/%b want=1/0", frame_done, drop_pulse); end
    repeat (4) tick(0, 16'h0000, 0, 1);
    clear_streams();
  endtask

  task automatic test_reset_mid_frame();
    tick(1, 16'hA55A, 0, 1);
    tick(0, 16'h0000, 0, 1);
    rst = 1'b1;
    tick(0, 16'h0000, 0, 0);
    rst = 1'b0;
    total++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_idle got=%b/%b want=0/0", tx_valid, busy); end
    total++; if (tx_valid0 !== 1'b0 || busy0 !== 1'b0) begin
      bad++; $display("FAIL abort_idle_nocarry got=%b/%b want=0/0", tx_valid0, busy0); end
    clear_streams();
    tick(1, 16'h1234, 1, 1);
    repeat (4) tick(0, 16'h0000, 0, 1);
    total++;
    if (got_q.size() != 3 || got_q[0] !== 8'h34 || got_q[1] !== 8'h12 || got_q[2] !== 8'h01) begin
      bad++; $display("FAIL fresh_frame got=%p want=34 12 01", got_q);
    end
    total++;
    if (got0_q.size() != 2 || got0_q[0] !== 8'h34 || got0_q[1] !== 8'h12) begin
      bad++; $display("FAIL fresh_frame_nocarry got=%p want=34 12", got0_q);
    end
    clear_streams();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 300; k++) begin
      tick(1, 16'(k), 0, 0);
      tick(0, 16'h0000, 0, 0);
    end
    total++; if (drop_count !== 8'hFF) begin bad++; $display("FAIL drop_saturate got=%h want=ff", drop_count); end
    rst = 1'b1;
    tick(0, 16'h0000, 0, 0);
    rst = 1'b0;
    total++; if (drop_count !== 8'h00) begin bad++; $display("FAIL drop_clear got=%h want=00", drop_count); end
    clear_streams();
  endtask

  task automatic test_random();
    clear_streams();
    for (int k = 0; k < 600; k++) begin
      tick(($urandom_range(0, 3) == 0), 16'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int k = 0; k < 40 && m_q.size() > 0; k++) tick(0, 16'h0000, 0, 1);
    tick(0, 16'h0000, 0, 1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL random_drain got=%b want=0", busy); end
    total++; if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL random_len got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      total++;
      if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL random_byte%0d got=%h want=%h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_model_agreement();
    total++; if (vmis != 0) begin bad++; $display("FAIL valid_busy_track got=%0d want=0", vmis); end
    total++; if (fdmis != 0) begin bad++; $display("FAIL frame_done_track got=%0d want=0", fdmis); end
    total++; if (dpmis != 0) begin bad++; $display("FAIL drop_pulse_track got=%0d want=0", dpmis); end
    total++; if (dcmis != 0) begin bad++; $display("FAIL drop_count_track got=%0d want=0", dcmis); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_level_valid();
    test_drop_and_back_to_back();
    test_edge_on_last_byte();
    test_reset_mid_frame();
    test_saturation();
    test_random();
    test_model_agreement();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
